cmd_tx_queue: RTL and testbench

CMD_TX_QUEUE -- requirements
Module: cmd_tx_queue

---
 rtl/cmd_pkg.sv | 29 ++
 rtl/cmd_fifo_sync.sv | 57 +++++
 rtl/cmd_tx_queue.sv | 90 +++++++++
 tb/tb_cmd_tx_queue.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmd_pkg.sv
// Shared types and widths for the UART command transmit queue.
// One queue entry is the command byte packed above its 32-bit data field.
package cmd_pkg;

  localparam int CMD_W   = 8;
  localparam int DATA_W  = 32;
  localparam int ENTRY_W = CMD_W + DATA_W;
  localparam int LEVEL_W = 5;
  localparam int CNT_W   = 16;

  typedef enum logic [0:0] {
    ST_IDLE      = 1'b0,
    ST_WAIT_OVER = 1'b1
  } tx_state_t;

  typedef struct packed {
    logic [CMD_W-1:0]  cmd;
    logic [DATA_W-1:0] data;
  } cmd_entry_t;

  function automatic cmd_entry_t pack_entry(input logic [CMD_W-1:0] cmd,
                                            input logic [DATA_W-1:0] data);
    cmd_entry_t e;
    e.cmd  = cmd;
    e.data = data;
    return e;
  endfunction

endpackage

// File: rtl/cmd_fifo_sync.sv
// Synchronous FIFO of command entries with registered pointers and level.
// Pushes while full and pops while empty are silently dropped.
module cmd_fifo_sync
  import cmd_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  cmd_entry_t         push_entry,
  input  logic               pop,
  output cmd_entry_t         head,
  output logic               full,
  output logic               empty,
  output logic [LEVEL_W-1:0] level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [LEVEL_W-1:0] FULL_LEVEL = LEVEL_W'(DEPTH);

  cmd_entry_t         mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [LEVEL_W-1:0] level_q;
  logic               do_push;
  logic               do_pop;

  assign full    = (level_q == FULL_LEVEL);
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_entry;
  end

endmodule

// File: rtl/cmd_tx_queue.sv
// Queues commands and hands them one at a time to the UART command
// transmitter, waiting for completion or a timeout before the next issue.
module cmd_tx_queue
  import cmd_pkg::*;
#(
  parameter int DEPTH          = 8,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push_valid,
  input  logic [CMD_W-1:0]   push_cmd,
  input  logic [DATA_W-1:0]  push_data,
  output logic               push_ready,
  output logic               command_tx_ready,
  output logic [CMD_W-1:0]   command_tx,
  output logic [DATA_W-1:0]  data_field_tx,
  input  logic               command_tx_status,
  input  logic               command_tx_over,
  output logic [LEVEL_W-1:0] queue_level,
  output logic               tx_timeout_err,
  input  logic               err_clr
);

  localparam logic [CNT_W-1:0] TIMEOUT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

  tx_state_t          state;
  logic [CNT_W-1:0]   wait_cnt;
  logic [CNT_W-1:0]   cnt_next;
  cmd_entry_t         head;
  logic               fifo_full;
  logic               fifo_empty;
  logic               pop;
  logic               timeout_hit;

  cmd_fifo_sync #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push_valid),
    .push_entry(pack_entry(push_cmd, push_data)),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (queue_level)
  );

  assign push_ready  = !fifo_full;
  assign pop         = (state == ST_IDLE) && !fifo_empty && !command_tx_status;
  assign cnt_next    = wait_cnt + 16'd1;
  // Completion wins over a timeout landing on the same cycle.
  assign timeout_hit = (state == ST_WAIT_OVER) && !command_tx_over &&
                       (cnt_next == TIMEOUT_LIMIT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= ST_IDLE;
      wait_cnt         <= '0;
      command_tx_ready <= 1'b0;
      command_tx       <= '0;
      data_field_tx    <= '0;
      tx_timeout_err   <= 1'b0;
    end else begin
      command_tx_ready <= 1'b0;
      // A fresh timeout must not be lost to a simultaneous clear.
      if (timeout_hit)  tx_timeout_err <= 1'b1;
      else if (err_clr) tx_timeout_err <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (pop) begin
            command_tx       <= head.cmd;
            data_field_tx    <= head.data;
            command_tx_ready <= 1'b1;
            wait_cnt         <= '0;
            state            <= ST_WAIT_OVER;
          end
        end
        ST_WAIT_OVER: begin
          if (command_tx_over || timeout_hit) state <= ST_IDLE;
          else                                wait_cnt <= cnt_next;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cmd_tx_queue.sv
// Directed bench for cmd_tx_queue: issue latency, ordering, full handling,
// completion spacing, timeout flag behaviour and mid-transaction reset.
module tb_cmd_tx_queue;

  localparam int DEPTH = 8;
  localparam int TMO   = 20;

  logic        clk = 1'b0;
  logic        reset;
  logic        push_valid;
  logic [7:0]  push_cmd;
  logic [31:0] push_data;
  logic        push_ready;
  logic        command_tx_ready;
  logic [7:0]  command_tx;
  logic [31:0] data_field_tx;
  logic        command_tx_status;
  logic        command_tx_over;
  logic [4:0]  queue_level;
  logic        tx_timeout_err;
  logic        err_clr;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int pulses = 0;

  cmd_tx_queue #(
    .DEPTH(DEPTH),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .push_valid       (push_valid),
    .push_cmd         (push_cmd),
    .push_data        (push_data),
    .push_ready       (push_ready),
    .command_tx_ready (command_tx_ready),
    .command_tx       (command_tx),
    .data_field_tx    (data_field_tx),
    .command_tx_status(command_tx_status),
    .command_tx_over  (command_tx_over),
    .queue_level      (queue_level),
    .tx_timeout_err   (tx_timeout_err),
    .err_clr          (err_clr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (command_tx_ready) pulses <= pulses + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    push_valid = 1'b0;
    push_cmd = '0;
    push_data = '0;
    command_tx_status = 1'b0;
    command_tx_over = 1'b0;
    err_clr = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic push_one(input logic [7:0] c, input logic [31:0] d);
    push_valid = 1'b1;
    push_cmd = c;
    push_data = d;
    tick();
    push_valid = 1'b0;
  endtask

  task automatic wait_ready(output bit seen);
    seen = command_tx_ready;
    for (int n = 0; n < 40 && !seen; n++) begin
      tick();
      seen = command_tx_ready;
    end
  endtask

  task automatic test_reset();
    apply_reset();
    total++; if (queue_level !== 5'd0) begin bad++; $display("FAIL reset_level: got %0d want 0", queue_level); end
    total++; if (push_ready !== 1'b1) begin bad++; $display("FAIL reset_push_ready: got %b want 1", push_ready); end
    total++; if (command_tx_ready !== 1'b0) begin bad++; $display("FAIL reset_tx_ready: got %b want 0", command_tx_ready); end
    total++; if (command_tx !== 8'h00) begin bad++; $display("FAIL reset_cmd: got %h want 00", command_tx); end
    total++; if (data_field_tx !== 32'h0) begin bad++; $display("FAIL reset_data: got %h want 0", data_field_tx); end
    total++; if (tx_timeout_err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", tx_timeout_err); end
  endtask

  task automatic test_single_issue();
    push_one(8'h01, 32'h02030405);
    total++; if (command_tx_ready !== 1'b0) begin bad++; $display("FAIL single_early: got %b want 0", command_tx_ready); end
    total++; if (queue_level !== 5'd1) begin bad++; $display("FAIL single_level1: got %0d want 1", queue_level); end
    tick();
    total++; if (command_tx_ready !== 1'b1) begin bad++; $display("FAIL single_pulse: got %b want 1", command_tx_ready); end
    total++; if (command_tx !== 8'h01) begin bad++; $display("FAIL single_cmd: got %h want 01", command_tx); end
    total++; if (data_field_tx !== 32'h02030405) begin bad++; $display("FAIL single_data: got %h want 02030405", data_field_tx); end
    total++; if (queue_level !== 5'd0) begin bad++; $display("FAIL single_level0: got %0d want 0", queue_level); end
    tick();
    total++; if (command_tx_ready !== 1'b0) begin bad++; $display("FAIL single_width: got %b want 0", command_tx_ready); end
    total++; if (command_tx !== 8'h01) begin bad++; $display("FAIL single_hold: got %h want 01", command_tx); end
    command_tx_over = 1'b1;
    tick();
    command_tx_over = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (command_tx_ready !== 1'b0) begin bad++; $display("FAIL single_extra_pulse: got %b want 0", command_tx_ready); end
    end
  endtask

  task automatic test_fill_and_drain();
    bit seen;
    command_tx_status = 1'b1;
    for (int i = 0; i < 8; i++) push_one(8'h10 + 8'(i), 32'hA000_0000 + 32'(i));
    total++; if (queue_level !== 5'd8) begin bad++; $display("FAIL full_level: got %0d want 8", queue_level); end
    total++; if (push_ready !== 1'b0) begin bad++; $display("FAIL full_push_ready: got %b want 0", push_ready); end
    push_one(8'hFF, 32'hDEADBEEF);
    total++; if (queue_level !== 5'd8) begin bad++; $display("FAIL full_ignored: got %0d want 8", queue_level); end
    command_tx_status = 1'b0;
    for (int i = 0; i < 8; i++) begin
      wait_ready(seen);
      total++; if (!seen) begin bad++; $display("FAIL drain_timeout: entry %0d never issued", i); end
      total++; if (command_tx !== 8'h10 + 8'(i)) begin bad++; $display("FAIL drain_cmd: got %h want %h", command_tx, 8'h10 + 8'(i)); end
      total++; if (data_field_tx !== 32'hA000_0000 + 32'(i)) begin bad++; $display("FAIL drain_data: got %h want %h", data_field_tx, 32'hA000_0000 + 32'(i)); end
      command_tx_over = 1'b1;
      tick();
      command_tx_over = 1'b0;
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (command_tx_ready !== 1'b0) begin bad++; $display("FAIL drain_ninth: got %b want 0 (cmd %h)", command_tx_ready, command_tx); end
    end
    total++; if (queue_level !== 5'd0) begin bad++; $display("FAIL drain_level: got %0d want 0", queue_level); end
  endtask

  task automatic test_back_to_back();
    bit seen;
    int last;
    int p0;
    command_tx_status = 1'b1;
    for (int i = 0; i < 3; i++) push_one(8'h21 + 8'(i), 32'h0000_00B0 + 32'(i));
    p0 = pulses;
    last = 0;
    command_tx_status = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wait_ready(seen);
      total++; if (!seen) begin bad++; $display("FAIL b2b_timeout: entry %0d never issued", i); end
      if (i > 0) begin
        total++; if (cyc - last != 11) begin bad++; $display("FAIL b2b_spacing: got %0d want 11", cyc - last); end
      end
      last = cyc;
      total++; if (command_tx !== 8'h21 + 8'(i)) begin bad++; $display("FAIL b2b_cmd: got %h want %h", command_tx, 8'h21 + 8'(i)); end
      repeat (9) tick();
      command_tx_over = 1'b1;
      tick();
      command_tx_over = 1'b0;
    end
    tick();
    tick();
    total++; if (pulses - p0 != 3) begin bad++; $display("FAIL b2b_pulses: got %0d want 3", pulses - p0); end
    total++; if (queue_level !== 5'd0) begin bad++; $display("FAIL b2b_level: got %0d want 0", queue_level); end
  endtask

  task automatic test_timeout();
    bit seen;
    command_tx_status = 1'b1;
    push_one(8'h31, 32'h1111_0031);
    push_one(8'h32, 32'h1111_0032);
    command_tx_status = 1'b0;
    wait_ready(seen);
    total++; if (!seen || command_tx !== 8'h31) begin bad++; $display("FAIL tmo_first: seen %b cmd %h want 31", seen, command_tx); end
    repeat (19) tick();
    total++; if (tx_timeout_err !== 1'b0) begin bad++; $display("FAIL tmo_early: got %b want 0", tx_timeout_err); end
    tick();
    total++; if (tx_timeout_err !== 1'b1) begin bad++; $display("FAIL tmo_set: got %b want 1", tx_timeout_err); end
    tick();
    total++; if (command_tx_ready !== 1'b1 || command_tx !== 8'h32) begin bad++; $display("FAIL tmo_next: ready %b cmd %h want 1/32", command_tx_ready, command_tx); end
    total++; if (tx_timeout_err !== 1'b1) begin bad++; $display("FAIL tmo_sticky: got %b want 1", tx_timeout_err); end
    err_clr = 1'b1;
    command_tx_over = 1'b1;
    tick();
    err_clr = 1'b0;
    command_tx_over = 1'b0;
    total++; if (tx_timeout_err !== 1'b0) begin bad++; $display("FAIL tmo_clear: got %b want 0", tx_timeout_err); end
    push_one(8'h33, 32'h1111_0033);
    wait_ready(seen);
    total++; if (!seen) begin bad++; $display("FAIL tmo_third: never issued"); end
    repeat (19) tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    total++; if (tx_timeout_err !== 1'b1) begin bad++; $display("FAIL tmo_clr_collide: got %b want 1", tx_timeout_err); end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    total++; if (tx_timeout_err !== 1'b0) begin bad++; $display("FAIL tmo_clear2: got %b want 0", tx_timeout_err); end
  endtask

  task automatic test_push_pop();
    apply_reset();
    command_tx_status = 1'b1;
    for (int i = 0; i < 8; i++) push_one(8'h40 + 8'(i), 32'h4000_0000 + 32'(i));
    push_valid = 1'b1;
    push_cmd = 8'hEE;
    push_data = 32'hEEEE_EEEE;
    command_tx_status = 1'b0;
    tick();
    push_valid = 1'b0;
    total++; if (queue_level !== 5'd7) begin bad++; $display("FAIL pp_full_level: got %0d want 7", queue_level); end
    total++; if (command_tx_ready !== 1'b1 || command_tx !== 8'h40) begin bad++; $display("FAIL pp_full_issue: ready %b cmd %h want 1/40", command_tx_ready, command_tx); end
    apply_reset();
    command_tx_status = 1'b1;
    for (int i = 0; i < 3; i++) push_one(8'h50 + 8'(i), 32'h5000_0000 + 32'(i));
    push_valid = 1'b1;
    push_cmd = 8'h5F;
    push_data = 32'h5000_00FF;
    command_tx_status = 1'b0;
    tick();
    push_valid = 1'b0;
    total++; if (queue_level !== 5'd3) begin bad++; $display("FAIL pp_level3: got %0d want 3", queue_level); end
    total++; if (command_tx_ready !== 1'b1 || command_tx !== 8'h50) begin bad++; $display("FAIL pp_issue3: ready %b cmd %h want 1/50", command_tx_ready, command_tx); end
    apply_reset();
  endtask

  task automatic test_reset_mid();
    bit seen;
    command_tx_status = 1'b1;
    for (int i = 0; i < 5; i++) push_one(8'h60 + 8'(i), 32'h6000_0000 + 32'(i));
    command_tx_status = 1'b0;
    wait_ready(seen);
    total++; if (!seen || queue_level !== 5'd4) begin bad++; $display("FAIL rst_mid_setup: seen %b level %0d want 1/4", seen, queue_level); end
    reset = 1'b1;
    tick();
    total++; if (queue_level !== 5'd0) begin bad++; $display("FAIL rst_mid_level: got %0d want 0", queue_level); end
    total++; if (push_ready !== 1'b1) begin bad++; $display("FAIL rst_mid_push_ready: got %b want 1", push_ready); end
    total++; if (command_tx !== 8'h00) begin bad++; $display("FAIL rst_mid_cmd: got %h want 00", command_tx); end
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++; if (command_tx_ready !== 1'b0) begin bad++; $display("FAIL rst_mid_pulse: got %b want 0", command_tx_ready); end
    end
    push_one(8'h70, 32'h7000_0070);
    tick();
    total++; if (command_tx_ready !== 1'b1 || command_tx !== 8'h70) begin bad++; $display("FAIL rst_mid_new: ready %b cmd %h want 1/70", command_tx_ready, command_tx); end
    command_tx_over = 1'b1;
    tick();
    command_tx_over = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_issue();
    test_fill_and_drain();
    test_back_to_back();
    test_timeout();
    test_push_pop();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
